// File: rtl/spwm_pkg.sv
// Shared defaults, FSM encoding and period type for the SPWM carrier timebase.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spwm_pkg;

    localparam int              CNT_W      = 16;
    localparam logic [CNT_W-1:0] DEF_PERIOD = 16'd4096;
    localparam logic [CNT_W-1:0] MIN_PERIOD = 16'd4;

    // FSM encoding kept as plain constants so legacy tools see fixed codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef logic [CNT_W-1:0] period_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the external carrier sync input.
// Latency: 2 clk_in cycles from d_in to q_out.
// Backpressure: none. Only compiled when CARRIER_SYNC_EN is defined.
`ifdef CARRIER_SYNC_EN
module sync_2ff (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    // plain two-stage shift; first stage may go metastable
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule
`endif

// File: rtl/carrier_timebase_ctrl.sv
// Sawtooth carrier counter with 50% clk_out, wrap/half ticks and glitch-free period update.
// Latency: all outputs registered; a config transfer lands in the shadow one cycle later.
// Backpressure: cfg_ready low while a shadow period waits for the next wrap. Macro: CARRIER_SYNC_EN.
module carrier_timebase_ctrl #(
    parameter int               CNT_W      = spwm_pkg::CNT_W,
    parameter logic [CNT_W-1:0] DEF_PERIOD = spwm_pkg::DEF_PERIOD,
    parameter logic [CNT_W-1:0] MIN_PERIOD = spwm_pkg::MIN_PERIOD
) (
    input  logic             clk_in,
    input  logic             rst_n,
`ifdef CARRIER_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             enable,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] carrier,
    output logic             clk_out,
    output logic             tick_wrap,
    output logic             tick_half,
    output logic             running
);

    import spwm_pkg::*;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] carrier_q, carrier_d;
    logic [CNT_W-1:0] active_q,  active_d;
    logic [CNT_W-1:0] shadow_q,  shadow_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q,   cfg_err_d;
    logic             clk_out_q,   clk_out_d;
    logic             tick_wrap_q, tick_wrap_d;
    logic             tick_half_q, tick_half_d;
    logic             running_q,   running_d;

    logic             wrap;
    logic             force_wrap;
    logic             xfer;
    logic             apply;
    logic             sync_rise;
    logic [CNT_W-1:0] half_d;

`ifdef CARRIER_SYNC_EN
    logic sync_s;
    logic sync_prev_q;

    sync_2ff u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d_in   (sync_in),
        .q_out  (sync_s)
    );

    // remember last synchronised level for rising-edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_prev_q <= 1'b0;
        end else begin
            sync_prev_q <= sync_s;
        end
    end

    assign sync_rise = sync_s & ~sync_prev_q;
`else
    assign sync_rise = 1'b0;
`endif

    // next-state: FSM, counter, shadow handshake and registered output values
    always_comb begin
        state_d     = state_q;
        carrier_d   = carrier_q;
        active_d    = active_q;
        shadow_d    = shadow_q;
        cfg_ready_d = cfg_ready_q;
        apply       = 1'b0;

        // equality only: the counter can never pass active_period-1
        wrap       = (carrier_q == (active_q - ONE));
        // a sync edge in IDLE is meaningless, there is no period to restart
        force_wrap = sync_rise && (state_q != ST_IDLE);
        xfer       = cfg_valid && cfg_ready_q;

        case (state_q)
            ST_IDLE: begin
                carrier_d = '0;
                apply     = !cfg_ready_q;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wrap || force_wrap) begin
                    carrier_d = '0;
                    apply     = !cfg_ready_q;
                end else begin
                    carrier_d = carrier_q + ONE;
                end
                if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wrap || force_wrap) begin
                    carrier_d = '0;
                    apply     = !cfg_ready_q;
                end else begin
                    carrier_d = carrier_q + ONE;
                end
                // stopping only at a period boundary means no runt period
                if (enable) begin
                    state_d = ST_RUN;
                end else if (wrap || force_wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                carrier_d = '0;
            end
        endcase

        // shadow is only ever full when cfg_ready is low, so apply and xfer never collide
        if (apply) begin
            active_d    = shadow_q;
            cfg_ready_d = 1'b1;
        end
        if (xfer) begin
            shadow_d    = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
            cfg_ready_d = 1'b0;
        end
        cfg_err_d = xfer && (cfg_period < MIN_PERIOD);

        // outputs are derived from the next count so they line up with carrier
        running_d   = (state_d != ST_IDLE);
        half_d      = active_d >> 1;
        clk_out_d   = running_d && (carrier_d < half_d);
        tick_wrap_d = running_d && (carrier_d == (active_d - ONE));
        tick_half_d = running_d && (carrier_d == (half_d - ONE));
    end

    // state and output registers; reset discards any pending shadow
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            carrier_q   <= '0;
            active_q    <= DEF_PERIOD;
            shadow_q    <= DEF_PERIOD;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_wrap_q <= 1'b0;
            tick_half_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carrier_q   <= carrier_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            clk_out_q   <= clk_out_d;
            tick_wrap_q <= tick_wrap_d;
            tick_half_q <= tick_half_d;
            running_q   <= running_d;
        end
    end

    assign carrier   = carrier_q;
    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign clk_out   = clk_out_q;
    assign tick_wrap = tick_wrap_q;
    assign tick_half = tick_half_q;
    assign running   = running_q;

endmodule
